// File: rtl/enokida_mem_arbiter.sv
// enokida_mem_arbiter: shares one RI5CY-style memory data port between the
// data cache miss/writeback port (m0) and instruction fetch (m1). One
// transaction is in flight at a time. The winning request is captured in
// IDLE and replayed to memory. The grant and response are steered back to
// the captured owner.
// Optional feature: define ENOKIDA_ARB_ROUND_ROBIN_EN for round-robin
// arbitration. Without it, m0 has fixed priority.
module enokida_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [31:0]             m0_grant_count,
  output logic [31:0]             m1_grant_count,
  output logic [31:0]             contention_count
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_own;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_m0_cnt, r_m1_cnt, r_cont_cnt;
  logic                  w_both, w_latch, w_gnt, w_win;

  assign w_both  = m0_req_i && m1_req_i;
  assign w_latch = (r_state == S_IDLE) && (m0_req_i || m1_req_i);
  assign w_gnt   = (r_state == S_REQ) && mem_gnt_i;

`ifdef ENOKIDA_ARB_ROUND_ROBIN_EN
  // Last owner; reset to 1 so the first contention goes to m0.
  logic r_last;

  // Remember who was granted most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last <= 1'b1;
    else if (w_gnt) r_last <= r_own;
  end

  // On contention the requester that was not served last wins.
  assign w_win = w_both ? ~r_last : !m0_req_i;
`else
  // Fixed priority: m0 wins whenever it is requesting.
  assign w_win = !m0_req_i;
`endif

  // Read data is a plain fan-out; rvalid tells each side whether it applies.
  assign m0_rdata_o       = mem_rdata_i;
  assign m1_rdata_o       = mem_rdata_i;
  assign mem_addr_o       = r_addr;
  assign mem_we_o         = r_we;
  assign mem_be_o         = r_be;
  assign mem_wdata_o      = r_wdata;
  assign m0_grant_count   = r_m0_cnt;
  assign m1_grant_count   = r_m1_cnt;
  assign contention_count = r_cont_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus handshake decode; gnt/rvalid follow memory combinationally.
  always_comb begin
    w_next      = r_state;
    mem_req_o   = 1'b0;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    case (r_state)
      S_IDLE: if (m0_req_i || m1_req_i) w_next = S_REQ;
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          m0_gnt_o = !r_own;
          m1_gnt_o = r_own;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          m0_rvalid_o = !r_own;
          m1_rvalid_o = r_own;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the winner's request once; inputs are not looked at again until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own   <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_own   <= w_win;
      r_addr  <= w_win ? m1_addr_i  : m0_addr_i;
      r_we    <= w_win ? m1_we_i    : m0_we_i;
      r_be    <= w_win ? m1_be_i    : m0_be_i;
      r_wdata <= w_win ? m1_wdata_i : m0_wdata_i;
    end
  end

  // Saturating statistics: grants per owner and contended arbitration cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_cnt   <= '0;
      r_m1_cnt   <= '0;
      r_cont_cnt <= '0;
    end else begin
      if (w_gnt && !r_own && (r_m0_cnt != '1)) r_m0_cnt <= r_m0_cnt + 32'd1;
      if (w_gnt &&  r_own && (r_m1_cnt != '1)) r_m1_cnt <= r_m1_cnt + 32'd1;
      if ((r_state == S_IDLE) && w_both && (r_cont_cnt != '1))
        r_cont_cnt <= r_cont_cnt + 32'd1;
    end
  end

endmodule
